// File: rtl/weight_feeder.sv
// rtl/weight_feeder.sv - streams layer-0/layer-1 weight rows from on-chip stores; WEIGHT_FEEDER_FRAME_CNT_EN adds a layer-1 frame counter
module weight_feeder #(
    parameter int NUM_NEURONS = 128,
    parameter int IMG_SZ      = 784,
    parameter int OUTPUT_SZ   = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              get_weights0,
    input  logic                              get_weights1,
    output logic [NUM_NEURONS-1:0][31:0]      weights0,
    output logic [OUTPUT_SZ-1:0][31:0]        weights1,
    input  logic                              wr_en,
    input  logic                              wr_sel,
    input  logic [$clog2(IMG_SZ)-1:0]         wr_row,
    input  logic [$clog2(NUM_NEURONS)-1:0]    wr_col,
    input  logic [31:0]                       wr_data,
    output logic                              busy,
    output logic                              wr_drop,
    output logic [15:0]                       frame_cnt
);
    localparam int RW   = $clog2(IMG_SZ);
    localparam int CW0  = $clog2(NUM_NEURONS);
    localparam int RW1  = $clog2(NUM_NEURONS);
    localparam int CW1  = $clog2(OUTPUT_SZ);
    localparam int CNTW = $clog2(IMG_SZ + 2);
    localparam logic [CNTW-1:0] LAST0 = CNTW'(IMG_SZ);
    localparam logic [CNTW-1:0] LAST1 = CNTW'(NUM_NEURONS);

    typedef enum logic [1:0] {S_IDLE, S_STREAM0, S_STREAM1} state_t;

    logic [NUM_NEURONS-1:0][31:0] w0_mem [IMG_SZ];
    logic [OUTPUT_SZ-1:0][31:0]   w1_mem [NUM_NEURONS];

    state_t          state, state_next;
    logic [CNTW-1:0] row, row_next, rd_row;
    logic            load0, load1, done1;
    logic            start0, start1, wr_ok;

    assign busy = (state != S_IDLE);

    // Range checks are one bit wider so power-of-two sizes do not truncate to zero.
    always_comb begin
        wr_ok = 1'b0;
        if (!busy) begin
            if (wr_sel)
                wr_ok = ({1'b0, wr_row} < (RW + 1)'(NUM_NEURONS)) &&
                        ({1'b0, wr_col} < (CW0 + 1)'(OUTPUT_SZ));
            else
                wr_ok = ({1'b0, wr_row} < (RW + 1)'(IMG_SZ));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            if (wr_sel)
                w1_mem[wr_row[RW1-1:0]][wr_col[CW1-1:0]] <= wr_data;
            else
                w0_mem[wr_row][wr_col] <= wr_data;
        end
    end

    assign start1 = get_weights1;
    assign start0 = get_weights0 && !get_weights1 && (state != S_STREAM1);

    // row holds the next row to load; LAST is the zero guard cycle, LAST+1 exits.
    always_comb begin
        state_next = state;
        row_next   = row;
        rd_row     = '0;
        load0      = 1'b0;
        load1      = 1'b0;
        done1      = 1'b0;
        if (start1) begin
            state_next = S_STREAM1;
            row_next   = CNTW'(1);
            load1      = 1'b1;
        end else if (start0) begin
            state_next = S_STREAM0;
            row_next   = CNTW'(1);
            load0      = 1'b1;
        end else begin
            unique case (state)
                S_STREAM0: begin
                    if (row < LAST0) begin
                        load0    = 1'b1;
                        rd_row   = row;
                        row_next = row + CNTW'(1);
                    end else if (row == LAST0) begin
                        row_next = row + CNTW'(1);
                    end else begin
                        state_next = S_IDLE;
                        row_next   = '0;
                    end
                end
                S_STREAM1: begin
                    if (row < LAST1) begin
                        load1    = 1'b1;
                        rd_row   = row;
                        row_next = row + CNTW'(1);
                    end else if (row == LAST1) begin
                        row_next = row + CNTW'(1);
                    end else begin
                        state_next = S_IDLE;
                        row_next   = '0;
                        done1      = 1'b1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            row      <= '0;
            weights0 <= '0;
            weights1 <= '0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_next;
            row      <= row_next;
            weights0 <= load0 ? w0_mem[rd_row[RW-1:0]] : '0;
            weights1 <= load1 ? w1_mem[rd_row[RW1-1:0]] : '0;
            if (wr_en && !wr_ok)
                wr_drop <= 1'b1;
        end
    end

`ifdef WEIGHT_FEEDER_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (done1)
            frame_cnt <= frame_cnt + 16'd1;
    end
`else
    logic unused_done1;
    assign unused_done1 = done1;
    assign frame_cnt    = '0;
`endif

endmodule

// File: tb/tb_weight_feeder.sv
// tb/tb_weight_feeder.sv - randomized self-checking bench for weight_feeder against a row-level model
module tb_weight_feeder;
    localparam int NN = 128;
    localparam int IS = 784;
    localparam int OS = 10;

    logic               clk;
    logic               rst;
    logic               get_weights0;
    logic               get_weights1;
    logic [NN-1:0][31:0] weights0;
    logic [OS-1:0][31:0] weights1;
    logic               wr_en;
    logic               wr_sel;
    logic [9:0]         wr_row;
    logic [6:0]         wr_col;
    logic [31:0]        wr_data;
    logic               busy;
    logic               wr_drop;
    logic [15:0]        frame_cnt;

    weight_feeder dut (
        .clk(clk), .rst(rst),
        .get_weights0(get_weights0), .get_weights1(get_weights1),
        .weights0(weights0), .weights1(weights1),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .busy(busy), .wr_drop(wr_drop), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned m0 [IS][NN];
    bit          k0 [IS][NN];
    int unsigned m1 [NN][OS];
    int          checks = 0;
    int          errors = 0;
    int          exp_frames = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit g0, input bit g1);
        get_weights0 = g0;
        get_weights1 = g1;
        step();
        get_weights0 = 1'b0;
        get_weights1 = 1'b0;
    endtask

    task automatic wr(input bit sel, input int row, input int col, input logic [31:0] data,
                      input bit during_busy);
        wr_en = 1'b1; wr_sel = sel; wr_row = row[9:0]; wr_col = col[6:0]; wr_data = data;
        step();
        wr_en = 1'b0;
        if (!during_busy) begin
            if (sel) begin
                if (row < NN && col < OS) m1[row][col] = data;
            end else if (row < IS) begin
                m0[row][col] = data;
                k0[row][col] = 1'b1;
            end
        end
    endtask

    task automatic expect_stream0(input int from);
        int  b;
        bit  bad;
        for (int k = from; k < IS; k++) begin
            bad = 1'b0; b = 0;
            for (int n = 0; n < NN; n++)
                if (k0[k][n] && weights0[n] !== m0[k][n]) begin bad = 1'b1; b = n; end
            checks++;
            if (bad || weights1 !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stream0_row%0d col%0d got %h want %h busy %b w1zero %b",
                         k, b, weights0[b], m0[k][b], busy, weights1 === '0);
            end
            step();
        end
        checks++;
        if (weights0 !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stream0_zero_row got nonzero=%b busy %b want zero busy 1", weights0 !== '0, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || weights0 !== '0) begin
            errors++;
            $display("FAIL stream0_done busy %b want 0", busy);
        end
    endtask

    task automatic expect_stream1(input int from);
        logic [OS-1:0][31:0] e;
        for (int k = from; k < NN; k++) begin
            for (int o = 0; o < OS; o++) e[o] = m1[k][o];
            checks++;
            if (weights1 !== e || weights0 !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stream1_row%0d got %h want %h busy %b", k, weights1, e, busy);
            end
            step();
        end
        checks++;
        if (weights1 !== '0 || busy !== 1'b1 || frame_cnt !== exp_frames[15:0]) begin
            errors++;
            $display("FAIL stream1_zero_row got %h busy %b frame_cnt %0d want 0 1 %0d",
                     weights1, busy, frame_cnt, exp_frames);
        end
        step();
`ifdef WEIGHT_FEEDER_FRAME_CNT_EN
        exp_frames++;
`endif
        checks++;
        if (busy !== 1'b0 || frame_cnt !== exp_frames[15:0]) begin
            errors++;
            $display("FAIL stream1_done busy %b frame_cnt %0d want 0 %0d", busy, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; get_weights0 = 0; get_weights1 = 0;
        wr_en = 0; wr_sel = 0; wr_row = 0; wr_col = 0; wr_data = 0;
        step(); step(); step();
        checks++;
        if (busy !== 1'b0 || wr_drop !== 1'b0 || frame_cnt !== 16'd0 ||
            weights0 !== '0 || weights1 !== '0) begin
            errors++;
            $display("FAIL reset_state busy %b wr_drop %b frame_cnt %0d want 0 0 0", busy, wr_drop, frame_cnt);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || weights0 !== '0) begin
            errors++;
            $display("FAIL reset_release busy %b want 0", busy);
        end
    endtask

    task automatic test_load();
        int r, c;
        for (int i = 0; i < IS; i++) wr(1'b0, i, 5, i * 1000 + 5, 1'b0);
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(IS - 1);
            c = $urandom_range(NN - 1);
            if (c == 5) c = 6;
            wr(1'b0, r, c, $urandom, 1'b0);
        end
        for (int j = 0; j < NN; j++)
            for (int o = 0; o < OS; o++) wr(1'b1, j, o, j * 16 + o, 1'b0);
        for (int i = 0; i < 10; i++)
            wr(1'b1, $urandom_range(NN - 1), $urandom_range(OS - 1), $urandom, 1'b0);
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++;
            $display("FAIL load_no_drop wr_drop %b want 0", wr_drop);
        end
    endtask

    task automatic test_stream0();
        start(1'b1, 1'b0);
        checks++;
        if (weights0[5] !== 32'd5) begin
            errors++;
            $display("FAIL stream0_first got %0d want 5", weights0[5]);
        end
        expect_stream0(0);
    endtask

    task automatic test_stream1();
        start(1'b0, 1'b1);
        expect_stream1(0);
    endtask

    task automatic test_abort();
        start(1'b1, 1'b0);
        for (int i = 0; i < 99; i++) step();
        checks++;
        if (weights0[5] !== m0[99][5] || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_row99 got %0d want %0d", weights0[5], m0[99][5]);
        end
        start(1'b0, 1'b1);
        expect_stream1(0);
    endtask

    task automatic test_restart();
        logic [OS-1:0][31:0] e;
        int r;
        start(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step();
        start(1'b1, 1'b0);
        for (int o = 0; o < OS; o++) e[o] = m1[21][o];
        checks++;
        if (weights1 !== e || weights0 !== '0) begin
            errors++;
            $display("FAIL ignore_gw0_in_s1 got %h want %h", weights1, e);
        end
        r = $urandom_range(30);
        for (int i = 0; i < r; i++) step();
        start(1'b0, 1'b1);
        expect_stream1(0);
        start(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step();
        start(1'b1, 1'b0);
        expect_stream0(0);
    endtask

    task automatic test_both();
        start(1'b1, 1'b1);
        expect_stream1(0);
    endtask

    task automatic test_drop();
        start(1'b0, 1'b1);
        step(); step(); step();
        wr(1'b0, 3, 5, 32'hDEAD_BEEF, 1'b1);
        expect_stream1(4);
        checks++;
        if (wr_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy wr_drop %b want 1", wr_drop);
        end
        wr(1'b1, 4, 10, 32'h1234_5678, 1'b0);
        wr(1'b1, 200, 2, 32'h0BAD_0BAD, 1'b0);
        wr(1'b0, 800, 0, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (wr_drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_sticky wr_drop %b want 1", wr_drop);
        end
        start(1'b0, 1'b1);
        expect_stream1(0);
    endtask

    task automatic test_reset_mid();
        start(1'b1, 1'b0);
        for (int i = 0; i < 49; i++) step();
        rst = 1'b1;
        #1;
        exp_frames = 0;
        checks++;
        if (busy !== 1'b0 || weights0 !== '0 || weights1 !== '0 ||
            wr_drop !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid busy %b wr_drop %b frame_cnt %0d want 0 0 0", busy, wr_drop, frame_cnt);
        end
        step();
        rst = 1'b0;
        step();
        start(1'b1, 1'b0);
        expect_stream0(0);
        start(1'b0, 1'b1);
        expect_stream1(0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_stream0();
        test_stream1();
        test_abort();
        test_restart();
        test_both();
        test_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_feeder.md
WEIGHT_FEEDER -- requirements
Module: weight_feeder

Interface
REQ-001 SHALL have parameters: NUM_NEURONS, 128, hidden-layer width; IMG_SZ, 784, layer-0 rows; OUTPUT_SZ, 10, layer-1 width.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- get_weights0  in  1  one-cycle request to stream layer-0 rows.
- get_weights1  in  1  one-cycle request to stream layer-1 rows.
- weights0  out  NUM_NEURONS x 32  current layer-0 row, element n = W0[row][n].
- weights1  out  OUTPUT_SZ x 32  current layer-1 row, element o = W1[row][o].
- wr_en  in  1  load-port write strobe.
- wr_sel  in  1  0 = W0 store, 1 = W1 store.
- wr_row  in  $clog2(IMG_SZ)  row index.
- wr_col  in  $clog2(NUM_NEURONS)  column index.
- wr_data  in  32  weight word.
- busy  out  1  streaming in progress.
- wr_drop  out  1  sticky: a write was discarded.
- frame_cnt  out  16  completed layer-1 streams (macro-dependent).

Function
REQ-003 SHALL hold W0 store IMG_SZ x NUM_NEURONS x 32 and W1 store NUM_NEURONS x OUTPUT_SZ x 32.
REQ-004 SHALL implement FSM states S_IDLE, S_STREAM0, S_STREAM1.
REQ-005 S_IDLE: get_weights0 -> S_STREAM0 with row counter 0; get_weights1 -> S_STREAM1 with row counter 0; both same cycle -> S_STREAM1.
REQ-006 Request at cycle T SHALL make row 0 visible on its output at T+1, row k at T+1+k (one word per cycle, no stalls).
REQ-007 S_STREAM0 SHALL run IMG_SZ+1 cycles; cycle IMG_SZ+1 after request SHALL output an all-zero row (over-read guard), then return to S_IDLE.
REQ-008 S_STREAM1 SHALL run NUM_NEURONS+1 cycles; final cycle outputs an all-zero row, then returns to S_IDLE.
REQ-009 get_weights1 during S_STREAM0 SHALL abort the layer-0 stream and start S_STREAM1 at row 0 per REQ-006; get_weights0 during S_STREAM0 SHALL restart at row 0.
REQ-010 get_weights0 during S_STREAM1 SHALL be ignored; get_weights1 during S_STREAM1 SHALL restart at row 0.
REQ-011 Output bus not being streamed SHALL be all zero; both buses zero in S_IDLE.
REQ-012 busy SHALL be 1 in S_STREAM0/S_STREAM1, else 0.
REQ-013 Write with busy=0 SHALL update the addressed word, visible to a stream requested the next cycle or later.
REQ-014 Write with busy=1, or wr_sel=1 with wr_row>=NUM_NEURONS or wr_col>=OUTPUT_SZ, or wr_row>=IMG_SZ, SHALL be discarded and set wr_drop; wr_drop clears only on reset.
REQ-015 Row counter SHALL be sized to reach IMG_SZ without wrap.

Reset
REQ-016 rst SHALL asynchronously force S_IDLE, row counter 0, weights0/weights1 0, busy 0, wr_drop 0, frame_cnt 0.
REQ-017 Weight stores SHALL NOT be reset; contents survive rst.
REQ-018 rst mid-stream SHALL abort immediately; the next request streams from row 0.

Configuration
REQ-019 Macro WEIGHT_FEEDER_FRAME_CNT_EN defined: frame_cnt increments (wrapping 0xFFFF->0) when S_STREAM1 completes its final cycle; aborted/restarted streams do not count.
REQ-020 Macro undefined: no counter logic; frame_cnt tied to 0.

Verification
REQ-021 Load W0[r][n]=r*1000+n, pulse get_weights0 at T -> weights0[5]=5 at T+1, weights0[5]=783005 at T+784, all-zero at T+785, busy 0 at T+786.
REQ-022 Load W1[j][o]=j*16+o, pulse get_weights1 -> weights1[3] = 3,19,35,... for rows 0..127, then zero; with macro frame_cnt 0->1.
REQ-023 get_weights0 at T, get_weights1 at T+100 -> weights0 zero from T+101, weights1 row 0 at T+101; frame_cnt unchanged until layer-1 completes.
REQ-024 Write during busy, and write wr_sel=1 wr_col=10 while idle -> word unchanged, wr_drop=1 and held until rst.
REQ-025 rst asserted at T+50 of a layer-0 stream -> busy and outputs 0 immediately; re-request streams row 0 with pre-reset weight contents intact.
